// File: rtl/fetch_rv32i_pkg.sv
// Shared types and constants for the RV32I instruction fetch unit.
package fetch_rv32i_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

  typedef enum logic {ST_RESET, ST_RUN} fetch_st_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } buf_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Instruction buffer: synchronous FIFO of {inst, pc} entries with flush.
module fetch_buf
  import fetch_rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  buf_entry_t                   i_push_data,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output buf_entry_t                   o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  buf_entry_t    mem_q [DEPTH];
  buf_entry_t    mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = i_pop && (count_q != '0);
    do_push  = i_push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = i_push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_empty = (count_q == '0);

endmodule

// File: rtl/fetch_rv32i.sv
// RV32I fetch unit: credit-limited word requests, in-order response buffering,
// and redirect flush with discard of stale in-flight responses.
module fetch_rv32i
  import fetch_rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  localparam int CW = $clog2(BUF_DEPTH+1);

  fetch_st_e     state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] buf_count;
  logic [CW:0]   credit_used;
  logic [31:0]   redir_tgt;
  logic          buf_empty, req_fire, push, pop;
  buf_entry_t    head, push_data;

  // Outstanding requests plus buffered entries never exceed the buffer size,
  // so every response is guaranteed a slot.
  assign credit_used      = {1'b0, inflight_q} + {1'b0, buf_count};
  assign o_imem_req_valid = (state_q == ST_RUN) && (credit_used < (CW+1)'(BUF_DEPTH));
  assign o_imem_req_addr  = fetch_pc_q;

  always_comb begin
    state_d        = ST_RUN;
    redir_tgt      = align_pc(i_redirect_pc);
    req_fire       = o_imem_req_valid && i_imem_req_ready;
    push           = i_imem_rsp_valid && (drop_q == '0) && !i_redirect;
    pop            = o_inst_valid && i_inst_ready && !i_redirect;
    push_data.inst = i_imem_rsp_data;
    push_data.pc   = rsp_pc_q;
    inflight_d     = inflight_q + CW'(req_fire) - CW'(i_imem_rsp_valid);

    // After a redirect every request still outstanding belongs to the old stream.
    if (i_redirect)                           drop_d = inflight_d;
    else if (i_imem_rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
    else                                      drop_d = drop_q;

    if (i_redirect)    fetch_pc_d = redir_tgt;
    else if (req_fire) fetch_pc_d = fetch_pc_q + PC_INC;
    else               fetch_pc_d = fetch_pc_q;

    if (i_redirect) rsp_pc_d = redir_tgt;
    else if (push)  rsp_pc_d = rsp_pc_q + PC_INC;
    else            rsp_pc_d = rsp_pc_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_RESET;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push),
    .i_push_data (push_data),
    .i_pop       (pop),
    .i_flush     (i_redirect),
    .o_head      (head),
    .o_count     (buf_count),
    .o_empty     (buf_empty)
  );

  assign o_inst_valid = !buf_empty;
  assign o_inst       = head.inst;
  assign o_inst_pc    = head.pc;

endmodule
